// File: rtl/display_pkg.sv
// Shared constants and helpers for the countdown display: segment patterns
// (active-low, a..g on bits 6..0), the digit decode table and a power-of-ten helper.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Entry k is the active-low pattern for decimal digit k.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] pat;
        pat = SEG_BLANK;
        if (nibble <= 4'd9) begin
            pat = SEG_TABLE[nibble];
        end
        return pat;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/countdown_display_if.sv
// Value-load handshake between the light controller (master) and the display (slave).
interface countdown_display_if #(
    parameter int unsigned BIN_W = 14
) ();

    logic [BIN_W-1:0] value;
    logic             value_valid;
    logic             value_ready;

    modport master (
        output value,
        output value_valid,
        input  value_ready
    );

    modport slave (
        input  value,
        input  value_valid,
        output value_ready
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: accepts one binary value per handshake,
// emits DIGITS BCD nibbles, an out-of-range flag and a one-cycle done pulse.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    countdown_display_if.slave      bus,
    output logic [4*DIGITS-1:0]     o_bcd,
    output logic                    o_overflow,
    output logic                    o_done
);

    localparam int unsigned    BCD_W   = 4 * DIGITS;
    localparam int unsigned    SR_W    = BCD_W + BIN_W;
    localparam int unsigned    CNT_W   = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  r_shift;
    logic [SR_W-1:0]  w_adj;
    logic [SR_W-1:0]  w_dabbled;
    logic             r_ovf;
    logic             r_done;
    logic             r_ready;
    logic             w_xfer;
    logic             w_last_iter;

    assign w_xfer      = bus.value_valid && r_ready;
    assign w_last_iter = (r_cnt == CNT_W'(BIN_W - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_xfer) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last_iter) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // One dabble step: +3 on every nibble >= 5, then shift left by one
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_shift[BIN_W + 4*i +: 4] >= 4'd5) begin
                w_adj[BIN_W + 4*i +: 4] = r_shift[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        w_dabbled = {w_adj[SR_W-2:0], 1'b0};
    end

    // Datapath and handshake registers; ready only follows an IDLE next state,
    // so it stays low for the first cycle after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_next == ST_IDLE);
            r_done  <= (r_state == ST_SHIFT) && (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_shift <= {BCD_W'(0), bus.value};
                        r_cnt   <= '0;
                        r_ovf   <= (64'(bus.value) > MAX_VAL);
                    end
                end
                ST_SHIFT: begin
                    r_shift <= w_dabbled;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.value_ready = r_ready;
    assign o_bcd           = r_shift[SR_W-1 -: BCD_W];
    assign o_overflow      = r_ovf;
    assign o_done          = r_done;

endmodule

// File: rtl/countdown_display.sv
// Countdown display top: binary value in, scanned active-low 7-segment digits out.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero one.
module countdown_display
    import display_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned REFRESH_DIV = 65536
) (
    input  logic               clk,
    input  logic               rst,
    countdown_display_if.slave bus,
    output logic [6:0]         seg,
    output logic [7:0]         AN
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
    localparam int unsigned SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [BCD_W-1:0]  w_bcd;
    logic              w_ovf;
    logic              w_done;

    logic [REF_W-1:0]  r_refresh;
    logic [SCAN_W-1:0] r_scan;
    logic [BCD_W-1:0]  r_disp_bcd;
    logic              r_disp_ovf;

    logic              w_refresh_wrap;
    logic              w_scan_last;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_conv (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_bcd      (w_bcd),
        .o_overflow (w_ovf),
        .o_done     (w_done)
    );

    assign w_refresh_wrap = (r_refresh == REF_W'(REFRESH_DIV - 1));
    assign w_scan_last    = (r_scan == SCAN_W'(DIGITS - 1));

    // Refresh divider and scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_scan    <= '0;
        end else if (w_refresh_wrap) begin
            r_refresh <= '0;
            r_scan    <= w_scan_last ? '0 : r_scan + SCAN_W'(1);
        end else begin
            r_refresh <= r_refresh + REF_W'(1);
        end
    end

    // Display register: an out-of-range result keeps the old digits and raises the dash flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_bcd <= '0;
            r_disp_ovf <= 1'b0;
        end else if (w_done) begin
            if (w_ovf) begin
                r_disp_ovf <= 1'b1;
            end else begin
                r_disp_ovf <= 1'b0;
                r_disp_bcd <= w_bcd;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_blank;
    logic              w_zero_above;

    // Digit i is blank when it and every digit above it are zero; digit 0 never is
    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_disp_bcd[4*i +: 4] == 4'd0);
            w_blank[i]   = w_zero_above;
        end
    end
`endif

    // Segment pattern for the digit in the current scan slot
    always_comb begin
        w_seg = SEG_BLANK;
        w_nib = r_disp_bcd[{r_scan, 2'b00} +: 4];
        if (r_disp_ovf) begin
            w_seg = SEG_DASH;
        end
`ifdef LEADING_ZERO_BLANK_EN
        else if (w_blank[r_scan]) begin
            w_seg = SEG_BLANK;
        end
`endif
        else begin
            w_seg = seg_decode(w_nib);
        end
    end

    // AN and seg share the scan index so they switch on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            AN  <= 8'hFF;
            seg <= SEG_BLANK;
        end else begin
            AN  <= ~(8'd1 << r_scan);
            seg <= w_seg;
        end
    end

endmodule

// File: tb/tb_countdown_display.sv
// Scoreboard bench for countdown_display: stimulus queues expected digits, a monitor
// checks them (plus handshake busy time) each time value_ready rises.
module tb_countdown_display;

    localparam int unsigned DIGITS      = 4;
    localparam int unsigned BIN_W       = 14;
    localparam int unsigned REFRESH_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [7:0] AN;

    always #5 clk = ~clk;

    countdown_display_if #(.BIN_W(BIN_W)) bus ();

    countdown_display #(
        .DIGITS      (DIGITS),
        .BIN_W       (BIN_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .seg (seg),
        .AN  (AN)
    );

    typedef struct {
        string       name;
        logic [15:0] bcd;
        bit          ovf;
        int          lowcyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [6:0] TB_SEG [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    function automatic logic [6:0] exp_seg(input exp_t e, input int slot);
        logic [15:0] b;
        logic [3:0]  nib;
        b   = e.bcd;
        nib = b[slot*4 +: 4];
        if (e.ovf) return 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (b >> (4*slot)) == 16'h0) return 7'h7F;
`endif
        return TB_SEG[int'(nib)];
    endfunction

    function automatic void push(input string nm, input logic [15:0] bcd,
                                 input bit ovf, input int lowcyc);
        exp_t e;
        e.name   = nm;
        e.bcd    = bcd;
        e.ovf    = ovf;
        e.lowcyc = lowcyc;
        sb.push_back(e);
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (bus.value_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.value_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: value_ready still %b after %0d cycles", bus.value_ready, n);
        end
        repeat (24) @(negedge clk);
    endtask

    task automatic send(input int v);
        int n = 0;
        @(negedge clk);
        while (bus.value_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.value_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: value_ready never high for value %0d", v);
        end
        bus.value       = BIN_W'(v);
        bus.value_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.value_valid = 1'b0;
    endtask

    // Monitor: on each value_ready rise, pop one expectation and check the scan
    exp_t       m_e;
    logic       m_prev = 1'b0;
    int         m_low  = 0;
    bit         m_seen [DIGITS];
    bit         m_an_ok;
    int         m_slot;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.value_ready === 1'b1 && m_prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: value_ready rose with no pending expectation");
                end else begin
                    m_e = sb.pop_front();
                    if (m_e.lowcyc >= 0) chk({m_e.name, "_busy_cycles"}, m_low, m_e.lowcyc);
                    foreach (m_seen[s]) m_seen[s] = 1'b0;
                    m_an_ok = 1'b1;
                    @(negedge clk);
                    for (int k = 0; k < int'(DIGITS * REFRESH_DIV); k++) begin
                        @(negedge clk);
                        m_slot = -1;
                        for (int s = 0; s < int'(DIGITS); s++) begin
                            if (AN == ~(8'd1 << s)) m_slot = s;
                        end
                        if (m_slot < 0) begin
                            m_an_ok = 1'b0;
                        end else if (!m_seen[m_slot]) begin
                            m_seen[m_slot] = 1'b1;
                            chk($sformatf("%s_seg_d%0d", m_e.name, m_slot), int'(seg),
                                int'(exp_seg(m_e, m_slot)));
                        end
                    end
                    foreach (m_seen[s]) if (!m_seen[s]) m_an_ok = 1'b0;
                    chk({m_e.name, "_an_scan"}, int'(m_an_ok), 1);
                end
                m_low  = 0;
                m_prev = bus.value_ready;
            end else begin
                if (bus.value_ready === 1'b0) m_low++;
                else m_low = 0;
                m_prev = bus.value_ready;
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.value       = '0;
        bus.value_valid = 1'b0;

        push("init", 16'h0000, 1'b0, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_AN", int'(AN), 'hFF);
        chk("rst_seg", int'(seg), 'h7F);
        chk("rst_ready", int'(bus.value_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(bus.value_ready), 1);
        wait_idle();

        push("v10", 16'h0010, 1'b0, 15);
        send(10);
        wait_idle();

        push("v9999", 16'h9999, 1'b0, 15);
        send(9999);
        wait_idle();

        push("v10000_ovf", 16'h9999, 1'b1, 15);
        send(10000);
        wait_idle();

        push("v5", 16'h0005, 1'b0, 15);
        send(5);
        wait_idle();

        // Request of 42 arrives while busy converting 7 and must be dropped
        push("v7_busy", 16'h0007, 1'b0, 15);
        send(7);
        repeat (3) @(negedge clk);
        bus.value       = BIN_W'(42);
        bus.value_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.value_valid = 1'b0;
        wait_idle();

        // Reset in the middle of converting 1234 must leave all zeros
        send(1234);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        push("rst_mid", 16'h0000, 1'b0, -1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_idle();

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
